// File: rtl/esram_pkg.sv
// esram_pkg: shared widths, pointer type and parity helper
// for the eSRAM-backed FIFO controller.
package esram_pkg;

  localparam int ESRAM_DATA_W = 72;
  localparam int ESRAM_ADDR_W = 11;
  localparam int ESRAM_DEPTH  = 2048;

  // One extra bit so full and empty are distinguishable.
  typedef logic [ESRAM_ADDR_W:0] ptr_t;

  function automatic logic [7:0] byte_par(
    input logic [63:0] d
  );
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/esram_out_fifo.sv
// esram_out_fifo: small register FIFO that absorbs eSRAM
// read data and presents the stream head.
module esram_out_fifo
  import esram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ESRAM_DATA_W-1:0] wr_data,
  input  logic                    rd_en,
  output logic [ESRAM_DATA_W-1:0] rd_data,
  output logic                    valid,
  output logic [CW-1:0]           count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ESRAM_DATA_W-1:0] mem_q [DEPTH];
  logic [ESRAM_DATA_W-1:0] mem_d [DEPTH];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] i
  );
    return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    if (wr_en) begin
      mem_d[wr_idx_q] = wr_data;
      wr_idx_d = nxt(wr_idx_q);
    end
    if (rd_en) begin
      rd_idx_d = nxt(rd_idx_q);
    end
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data = mem_q[rd_idx_q];
  assign valid   = (cnt_q != '0);
  assign count   = cnt_q;

endmodule

// File: rtl/esram_fifo_ctrl.sv
// esram_fifo_ctrl: 2048-word eSRAM FIFO with prefetch buffer.
// ESRAM_FIFO_PARITY_EN adds per-byte even parity on bits 71:64.
module esram_fifo_ctrl
  import esram_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ESRAM_DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ESRAM_DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [11:0]             occupancy,
  output logic                    parity_err,
  output logic [ESRAM_DATA_W-1:0] data,
  output logic [ESRAM_ADDR_W-1:0] wraddress,
  output logic                    wren_n,
  output logic [ESRAM_ADDR_W-1:0] rdaddress,
  output logic                    rden_n,
  output logic                    sd_n,
  input  logic [ESRAM_DATA_W-1:0] q
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic rdy_q, rdy_d;

  ptr_t ram_cnt, infl, occ;
  logic [CW-1:0] buf_cnt;
  logic push, issue, cap, pop, buf_valid;
  logic [ESRAM_DATA_W-1:0] cap_data;

  assign ram_cnt = wr_ptr_q - rd_ptr_q;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + ptr_t'(vld_q[i]);
    end
  end

  assign occ       = ram_cnt + infl + ptr_t'(buf_cnt);
  assign occupancy = occ;
  assign in_ready  = rdy_q && (occ < ptr_t'(ESRAM_DEPTH));

  // ram_cnt is registered, so a same-cycle write is never read.
  assign push  = in_valid && in_ready;
  assign issue = (ram_cnt != '0) &&
                 ((infl + ptr_t'(buf_cnt)) < ptr_t'(OUT_DEPTH));
  assign cap   = vld_q[RD_LAT-1];
  assign pop   = buf_valid && out_ready;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    wr_ptr_d = wr_ptr_q + ptr_t'(push);
    rd_ptr_d = rd_ptr_q + ptr_t'(issue);
    rdy_d    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
    end
  end

  assign wren_n    = !push;
  assign wraddress = wr_ptr_q[ESRAM_ADDR_W-1:0];
  assign rden_n    = !issue;
  assign rdaddress = rd_ptr_q[ESRAM_ADDR_W-1:0];
  assign sd_n      = 1'b1;

`ifdef ESRAM_FIFO_PARITY_EN
  logic [7:0] cap_par;
  assign data       = {byte_par(in_data[63:0]), in_data[63:0]};
  assign cap_par    = byte_par(q[63:0]);
  assign cap_data   = {cap_par, q[63:0]};
  assign parity_err = cap && (cap_par != q[71:64]);
`else
  assign data       = in_data;
  assign cap_data   = q;
  assign parity_err = 1'b0;
`endif

  esram_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .CW    (CW)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap),
    .wr_data (cap_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .valid   (buf_valid),
    .count   (buf_cnt)
  );

  assign out_valid = buf_valid;

endmodule

// File: tb/tb_esram_fifo_ctrl.sv
// tb_esram_fifo_ctrl: directed bench with a behavioural eSRAM
// model behind esram_fifo_ctrl.
module tb_esram_fifo_ctrl;

  localparam int RD_LAT = 2;
`ifdef ESRAM_FIFO_PARITY_EN
  localparam int PE_EXP = 1;
`else
  localparam int PE_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] occupancy;
  logic        parity_err;
  logic [71:0] data;
  logic [10:0] wraddress, rdaddress;
  logic        wren_n, rden_n, sd_n;
  logic [71:0] q;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  esram_fifo_ctrl #(.RD_LAT(RD_LAT), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .parity_err(parity_err),
    .data(data), .wraddress(wraddress), .wren_n(wren_n),
    .rdaddress(rdaddress), .rden_n(rden_n), .sd_n(sd_n), .q(q)
  );

  // eSRAM model: address sampled at the edge, q valid RD_LAT cycles
  // after the rden_n-low cycle.
  logic [71:0] mem [2048];
  logic [71:0] qpipe [RD_LAT];
  logic [RD_LAT-1:0] vpipe = '0;
  int rd_issued = 0, wr_wraps = 0, rd_wraps = 0;
  int cap_idx = 0, flip_at = -1;
  logic [10:0] last_wa = '0, last_ra = '0;

  assign q = qpipe[RD_LAT-1] ^
    ((vpipe[RD_LAT-1] && cap_idx == flip_at) ? 72'h20 : 72'h0);

  always @(posedge clk) begin
    if (!wren_n) begin
      mem[wraddress] <= data;
      if (wraddress == 11'd0 && last_wa == 11'd2047) wr_wraps <= wr_wraps + 1;
      last_wa <= wraddress;
    end
    if (!rden_n) begin
      rd_issued <= rd_issued + 1;
      if (rdaddress == 11'd0 && last_ra == 11'd2047) rd_wraps <= rd_wraps + 1;
      last_ra <= rdaddress;
    end
    qpipe[0] <= mem[rdaddress];
    vpipe[0] <= !rden_n;
    for (int i = 1; i < RD_LAT; i++) begin
      qpipe[i] <= qpipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
    if (vpipe[RD_LAT-1]) cap_idx <= cap_idx + 1;
  end

  function automatic logic [71:0] mkword(input int n);
    logic [31:0] u;
    u = n;
    return {u[7:0] ^ 8'h5a, ~u, u};
  endfunction

  function automatic logic [71:0] exp_of(input logic [71:0] w);
`ifdef ESRAM_FIFO_PARITY_EN
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^w[8*i +: 8];
    return {p, w[63:0]};
`else
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (occupancy !== 12'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    total++; if (wren_n !== 1'b1 || rden_n !== 1'b1) begin bad++; $display("FAIL rst_en_n got=%b%b want=11", wren_n, rden_n); end
    total++; if (sd_n !== 1'b1 || parity_err !== 1'b0) begin bad++; $display("FAIL rst_sd_pe got=%b%b want=10", sd_n, parity_err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_pre_edge got=%b want=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 72'h0AB;
    #1;
    total++; if (wren_n !== 1'b0 || wraddress !== 11'd0) begin bad++; $display("FAIL lat_write got=%b/%0d want=0/0", wren_n, wraddress); end
    total++; if (data !== exp_of(72'h0AB)) begin bad++; $display("FAIL lat_data got=%h want=%h", data, exp_of(72'h0AB)); end
    step();
    in_valid = 1'b0;
    total++; if (rden_n !== 1'b0 || rdaddress !== 11'd0) begin bad++; $display("FAIL lat_issue got=%b/%0d want=0/0", rden_n, rdaddress); end
    total++; if (occupancy !== 12'd1) begin bad++; $display("FAIL lat_occ got=%0d want=1", occupancy); end
    for (int k = 1; k < 4; k++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early k=%0d got=%b want=0", k, out_valid); end
      step();
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    total++; if (out_data !== exp_of(72'h0AB)) begin bad++; $display("FAIL lat_out got=%h want=%h", out_data, exp_of(72'h0AB)); end
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 12'd0) begin bad++; $display("FAIL lat_empty got=%b/%0d want=0/0", out_valid, occupancy); end
  endtask

  task automatic test_back_to_back();
    int first = -1, n = 0, gaps = 0, derr = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      in_data = 72'h100 + 72'(c);
      #1;
      if (out_valid) begin
        if (first < 0) first = c;
        else if (c != first + n) gaps++;
        if (out_data !== exp_of(72'h100 + 72'(n))) derr++;
        n++;
      end
      step();
    end
    in_valid = 1'b0;
    total++; if (n != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", n); end
    total++; if (first != 4) begin bad++; $display("FAIL b2b_first got=%0d want=4", first); end
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    total++; if (derr != 0) begin bad++; $display("FAIL b2b_data got=%0d want=0", derr); end
  endtask

  task automatic test_full();
    int acc = 0, cyc = 0, r0, got = 0, derr = 0;
    logic [71:0] bad_w = '0;
    out_ready = 1'b0;
    r0 = rd_issued;
    while (acc < 2048 && cyc < 2200) begin
      in_valid = 1'b1;
      in_data = 72'(acc);
      #1;
      if (acc == 2047) begin
        total++; if (occupancy !== 12'd2047 || in_ready !== 1'b1) begin bad++; $display("FAIL full_2047 got=%0d/%b want=2047/1", occupancy, in_ready); end
      end
      if (in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (acc != 2048) begin bad++; $display("FAIL full_accepts got=%0d want=2048", acc); end
    total++; if (in_ready !== 1'b0 || occupancy !== 12'd2048) begin bad++; $display("FAIL full_state got=%b/%0d want=0/2048", in_ready, occupancy); end
    repeat (5) step();
    total++; if (rd_issued - r0 != 4) begin bad++; $display("FAIL full_reads got=%0d want=4", rd_issued - r0); end
    total++; if (rden_n !== 1'b1) begin bad++; $display("FAIL full_rden got=%b want=1", rden_n); end
    out_ready = 1'b1;
    #1;
    total++; if (out_data !== exp_of(72'd0)) begin bad++; $display("FAIL full_head got=%h want=%h", out_data, exp_of(72'd0)); end
    step();
    out_ready = 1'b0;
    total++; if (occupancy !== 12'd2047 || in_ready !== 1'b1) begin bad++; $display("FAIL pop_2047 got=%0d/%b want=2047/1", occupancy, in_ready); end
    in_valid = 1'b1;
    in_data = 72'd2048;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (occupancy !== 12'd2047 || in_ready !== 1'b1) begin bad++; $display("FAIL pushpop_2047 got=%0d/%b want=2047/1", occupancy, in_ready); end
    out_ready = 1'b1;
    cyc = 0;
    while (got < 2047 && cyc < 3000) begin
      if (out_valid) begin
        if (out_data !== exp_of(72'(got + 2))) begin derr++; bad_w = out_data; end
        got++;
      end
      step();
      cyc++;
    end
    total++; if (got != 2047) begin bad++; $display("FAIL drain_count got=%0d want=2047", got); end
    total++; if (derr != 0) begin bad++; $display("FAIL drain_order got=%0d bad (last %h) want=0", derr, bad_w); end
    total++; if (occupancy !== 12'd0) begin bad++; $display("FAIL drain_occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_random();
    int sent = 0, recv = 0, derr = 0, oerr = 0, herr = 0, perr = 0, cyc = 0;
    int w0, r0;
    logic hold = 1'b0;
    logic [71:0] hold_d = '0;
    do_reset();
    w0 = wr_wraps;
    r0 = rd_wraps;
    while (recv < 5000 && cyc < 40000) begin
      in_valid = (sent < 5000) && ($urandom_range(0, 3) != 0);
      in_data = mkword(sent);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (occupancy !== 12'(sent - recv)) oerr++;
      if (hold && (!out_valid || out_data !== hold_d)) herr++;
      if (parity_err !== 1'b0) perr++;
      hold = out_valid && !out_ready;
      hold_d = out_data;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (out_data !== exp_of(mkword(recv))) derr++;
        recv++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (recv != 5000) begin bad++; $display("FAIL rnd_count got=%0d want=5000", recv); end
    total++; if (derr != 0) begin bad++; $display("FAIL rnd_order got=%0d want=0", derr); end
    total++; if (oerr != 0) begin bad++; $display("FAIL rnd_occ got=%0d want=0", oerr); end
    total++; if (herr != 0) begin bad++; $display("FAIL rnd_hold got=%0d want=0", herr); end
    total++; if (perr != 0) begin bad++; $display("FAIL rnd_parity got=%0d want=0", perr); end
    total++; if (wr_wraps - w0 != 2) begin bad++; $display("FAIL rnd_wr_wrap got=%0d want=2", wr_wraps - w0); end
    total++; if (rd_wraps - r0 != 2) begin bad++; $display("FAIL rnd_rd_wrap got=%0d want=2", rd_wraps - r0); end
  endtask

  task automatic test_reset_midop();
    int sv = 0, oc = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = mkword(100 + i);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    total++; if (occupancy !== 12'd7) begin bad++; $display("FAIL mid_occ got=%0d want=7", occupancy); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (occupancy !== 12'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%b want=0/0", occupancy, out_valid); end
    total++; if (in_ready !== 1'b0 || rden_n !== 1'b1) begin bad++; $display("FAIL mid_rst_ctl got=%b/%b want=0/1", in_ready, rden_n); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid) sv++;
      if (occupancy != 12'd0) oc++;
    end
    out_ready = 1'b0;
    total++; if (sv != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", sv); end
    total++; if (oc != 0) begin bad++; $display("FAIL mid_occ_after got=%0d want=0", oc); end
    total++; if (rdaddress !== 11'd0) begin bad++; $display("FAIL mid_rdaddr got=%0d want=0", rdaddress); end
  endtask

  task automatic test_parity();
    int pe = 0, n = 0, derr = 0;
    logic [71:0] w;
    do_reset();
    out_ready = 1'b1;
    flip_at = cap_idx + 1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 3);
      in_data = mkword(500 + c);
      #1;
      if (parity_err) pe++;
      if (out_valid) begin
        w = mkword(500 + n);
        if (n == 1) w = w ^ 72'h20;
        if (out_data !== exp_of(w)) derr++;
        n++;
      end
      step();
    end
    total++; if (pe != PE_EXP) begin bad++; $display("FAIL par_pulse got=%0d want=%0d", pe, PE_EXP); end
    total++; if (n != 3 || derr != 0) begin bad++; $display("FAIL par_words got=%0d/%0d want=3/0", n, derr); end
    flip_at = -1;
    pe = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 3);
      in_data = mkword(600 + c);
      #1;
      if (parity_err) pe++;
      step();
    end
    in_valid = 1'b0;
    total++; if (pe != 0) begin bad++; $display("FAIL par_clean got=%0d want=0", pe); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_full();
    test_random();
    test_reset_midop();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
